// File: rtl/gpio_ctrl_pkg.sv
// rtl/gpio_ctrl_pkg.sv - shared constants for the GPIO controller
// Purpose: register word indices, default pin count and arm-counter terminal value.
// Ports: none (package).
package gpio_ctrl_pkg;

  localparam int GPIO_WIDTH = 16;

  localparam logic [3:0] ADDR_DATA  = 4'd0;
  localparam logic [3:0] ADDR_DIR   = 4'd1;
  localparam logic [3:0] ADDR_PU    = 4'd2;
  localparam logic [3:0] ADDR_PD    = 4'd3;
  localparam logic [3:0] ADDR_IM    = 4'd4;
  localparam logic [3:0] ADDR_ITYPE = 4'd5;
  localparam logic [3:0] ADDR_IPOL  = 4'd6;
  localparam logic [3:0] ADDR_IS    = 4'd7;
  localparam logic [3:0] ADDR_OUT   = 4'd8;

  // Event detection is enabled once the arm counter reaches this value.
  localparam logic [1:0] ARM_DONE = 2'd3;

endpackage

// File: rtl/gpio_ctrl_if.sv
// rtl/gpio_ctrl_if.sv - single-cycle register strobe bus
// Purpose: groups the register access signals between bus glue and gpio_ctrl.
// Signals: reg_sel (access strobe), reg_wr (1 = write), reg_addr (word index),
//          reg_wdata (write data), reg_rdata (combinational read data).
// Modports: master drives the strobe/address/data, slave returns read data.
interface gpio_ctrl_if
  import gpio_ctrl_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH
);
  logic             reg_sel;
  logic             reg_wr;
  logic [3:0]       reg_addr;
  logic [WIDTH-1:0] reg_wdata;
  logic [WIDTH-1:0] reg_rdata;

  modport master (output reg_sel, reg_wr, reg_addr, reg_wdata, input reg_rdata);
  modport slave  (input reg_sel, reg_wr, reg_addr, reg_wdata, output reg_rdata);
endinterface

// File: rtl/gpio_sync.sv
// rtl/gpio_sync.sv - pad input synchronizer and per-pin event detector
// Purpose: s1/s2 synchronizer plus s3 history flop; flags edge or level events.
// Ports: i_clk, i_rst_n (async active-low), i_din (async pad input),
//        i_itype (1 = edge), i_ipol (1 = rising/high), o_sync (synchronized
//        input), o_event (per-pin event, not yet gated by arming).
module gpio_sync
  import gpio_ctrl_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_din,
  input  logic [WIDTH-1:0] i_itype,
  input  logic [WIDTH-1:0] i_ipol,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_event
);
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_s3;
  logic [WIDTH-1:0] w_match;
  logic [WIDTH-1:0] w_edge;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_din;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Pin currently sits at the active polarity.
  assign w_match = ~(r_s2 ^ i_ipol);
  // An edge is a change that landed on the active polarity.
  assign w_edge  = (r_s2 ^ r_s3) & w_match;

  assign o_sync  = r_s2;
  assign o_event = (i_itype & w_edge) | (~i_itype & w_match);
endmodule

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - register-mapped GPIO controller
// Purpose: output/direction/pull registers for the pad wrapper, synchronized
//          input readback and maskable per-pin interrupts.
// Ports: HCLK, HRESETn (async active-low), bus (register strobe slave),
//        gpio_din (async pad input), gpio_dout/gpio_dir/gpio_pu/gpio_pd
//        (pad controls), irq (OR of IS & IM).
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  gpio_ctrl_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_din,
  output logic [WIDTH-1:0] gpio_dout,
  output logic [WIDTH-1:0] gpio_dir,
  output logic [WIDTH-1:0] gpio_pu,
  output logic [WIDTH-1:0] gpio_pd,
  output logic             irq
);
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_pu;
  logic [WIDTH-1:0] r_pd;
  logic [WIDTH-1:0] r_im;
  logic [WIDTH-1:0] r_itype;
  logic [WIDTH-1:0] r_ipol;
  logic [WIDTH-1:0] r_is;
  logic [1:0]       r_arm;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_rdata;
  logic             w_wr;
  logic             w_rd;

  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .i_clk   (HCLK),
    .i_rst_n (HRESETn),
    .i_din   (gpio_din),
    .i_itype (r_itype),
    .i_ipol  (r_ipol),
    .o_sync  (w_sync),
    .o_event (w_event)
  );

  assign w_wr = bus.reg_sel & bus.reg_wr;
  assign w_rd = bus.reg_sel & ~bus.reg_wr;

  // Events are ignored until the synchronizer has flushed its reset zeros.
  assign w_set = (r_arm == ARM_DONE) ? w_event : '0;
  assign w_clr = (w_wr && (bus.reg_addr == ADDR_IS)) ? bus.reg_wdata : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_out   <= '0;
      r_dir   <= '0;
      r_pu    <= '0;
      r_pd    <= '0;
      r_im    <= '0;
      r_itype <= '0;
      r_ipol  <= '0;
      r_is    <= '0;
      r_arm   <= '0;
    end else begin
      if (r_arm != ARM_DONE) begin
        r_arm <= r_arm + 2'd1;
      end
      if (w_wr) begin
        case (bus.reg_addr)
          ADDR_DATA:  r_out   <= bus.reg_wdata;
          ADDR_DIR:   r_dir   <= bus.reg_wdata;
          ADDR_PU:    r_pu    <= bus.reg_wdata;
          ADDR_PD:    r_pd    <= bus.reg_wdata;
          ADDR_IM:    r_im    <= bus.reg_wdata;
          ADDR_ITYPE: r_itype <= bus.reg_wdata;
          ADDR_IPOL:  r_ipol  <= bus.reg_wdata;
          default:    ;
        endcase
      end
      // Set is applied after clear so a simultaneous event wins.
      r_is <= (r_is & ~w_clr) | w_set;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.reg_addr)
      ADDR_DATA:  w_rdata = w_sync;
      ADDR_DIR:   w_rdata = r_dir;
      ADDR_PU:    w_rdata = r_pu;
      ADDR_PD:    w_rdata = r_pd;
      ADDR_IM:    w_rdata = r_im;
      ADDR_ITYPE: w_rdata = r_itype;
      ADDR_IPOL:  w_rdata = r_ipol;
      ADDR_IS:    w_rdata = r_is;
      ADDR_OUT:   w_rdata = r_out;
      default:    w_rdata = '0;
    endcase
  end

  assign bus.reg_rdata = w_rd ? w_rdata : '0;

  assign gpio_dout = r_out;
  assign gpio_dir  = r_dir;
  assign gpio_pu   = r_pu;
  assign gpio_pd   = r_pd & ~r_pu;
  assign irq       = |(r_is & r_im);
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - self-checking bench for gpio_ctrl
module tb_gpio_ctrl;
  localparam int W = 16;

  logic         HCLK;
  logic         HRESETn;
  logic [W-1:0] gpio_din;
  logic [W-1:0] gpio_dout;
  logic [W-1:0] gpio_dir;
  logic [W-1:0] gpio_pu;
  logic [W-1:0] gpio_pd;
  logic         irq;

  int checks = 0;
  int errors = 0;

  gpio_ctrl_if #(.WIDTH(W)) bus ();

  gpio_ctrl #(.WIDTH(W)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .bus       (bus),
    .gpio_din  (gpio_din),
    .gpio_dout (gpio_dout),
    .gpio_dir  (gpio_dir),
    .gpio_pu   (gpio_pu),
    .gpio_pd   (gpio_pd),
    .irq       (irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Reference model: register state, pin history as sampled on each edge,
  // and the number of edges since reset release.
  logic [W-1:0] m_out, m_dir, m_pu, m_pd, m_im, m_itype, m_ipol, m_is;
  logic [W-1:0] hist [0:2];
  int           edges;
  logic [W-1:0] m_ev;
  logic [W-1:0] m_w1c;

  // Logic sees the pin value from two edges ago; events only after 3 edges.
  always_comb begin
    m_ev = '0;
    if (edges >= 3) begin
      for (int i = 0; i < W; i++) begin
        if (m_itype[i])
          m_ev[i] = (hist[1][i] != hist[2][i]) && (hist[1][i] == m_ipol[i]);
        else
          m_ev[i] = (hist[1][i] == m_ipol[i]);
      end
    end
    m_w1c = (bus.reg_sel && bus.reg_wr && bus.reg_addr == 4'd7) ? bus.reg_wdata : '0;
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_out <= '0; m_dir <= '0; m_pu <= '0; m_pd <= '0;
      m_im <= '0; m_itype <= '0; m_ipol <= '0; m_is <= '0;
      hist[0] <= '0; hist[1] <= '0; hist[2] <= '0;
      edges <= 0;
    end else begin
      hist[0] <= gpio_din;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      if (edges < 3) edges <= edges + 1;
      if (bus.reg_sel && bus.reg_wr) begin
        case (bus.reg_addr)
          4'd0: m_out   <= bus.reg_wdata;
          4'd1: m_dir   <= bus.reg_wdata;
          4'd2: m_pu    <= bus.reg_wdata;
          4'd3: m_pd    <= bus.reg_wdata;
          4'd4: m_im    <= bus.reg_wdata;
          4'd5: m_itype <= bus.reg_wdata;
          4'd6: m_ipol  <= bus.reg_wdata;
          default: ;
        endcase
      end
      m_is <= (m_is & ~m_w1c) | m_ev;
    end
  end

  function automatic logic [W-1:0] model_read(input logic [3:0] a);
    case (a)
      4'd0: return hist[1];
      4'd1: return m_dir;
      4'd2: return m_pu;
      4'd3: return m_pd;
      4'd4: return m_im;
      4'd5: return m_itype;
      4'd6: return m_ipol;
      4'd7: return m_is;
      4'd8: return m_out;
      default: return '0;
    endcase
  endfunction

  task automatic bus_write(input logic [3:0] a, input logic [W-1:0] d);
    @(negedge HCLK);
    bus.reg_sel = 1'b1; bus.reg_wr = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
    @(posedge HCLK); #1;
    bus.reg_sel = 1'b0; bus.reg_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [W-1:0] d);
    @(negedge HCLK);
    bus.reg_sel = 1'b1; bus.reg_wr = 1'b0; bus.reg_addr = a;
    #1 d = bus.reg_rdata;
    @(posedge HCLK); #1;
    bus.reg_sel = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    gpio_din = '1;
    repeat (3) @(posedge HCLK);
    #2;
    for (int a = 0; a < 16; a++) begin
      bus.reg_sel = 1'b1; bus.reg_wr = 1'b0; bus.reg_addr = 4'(a);
      #1;
      checks++;
      if (bus.reg_rdata !== '0) begin
        errors++; $display("FAIL reset_read[%0d]: got %h expected 0000", a, bus.reg_rdata);
      end
    end
    bus.reg_sel = 1'b0;
    checks++;
    if ({gpio_dout, gpio_dir, gpio_pu, gpio_pd, irq} !== '0) begin
      errors++; $display("FAIL reset_pins: dout=%h dir=%h pu=%h pd=%h irq=%b expected all 0",
                         gpio_dout, gpio_dir, gpio_pu, gpio_pd, irq);
    end
  endtask

  // Pins held high through release with edge/rising configured before the
  // synchronizer has flushed: no interrupt may be latched.
  task automatic test_arming();
    logic [W-1:0] d;
    @(negedge HCLK);
    HRESETn = 1'b1;
    bus.reg_sel = 1'b1; bus.reg_wr = 1'b1; bus.reg_addr = 4'd5; bus.reg_wdata = '1;
    @(posedge HCLK); #1;
    bus.reg_sel = 1'b0; bus.reg_wr = 1'b0;
    bus_write(4'd6, '1);
    repeat (6) @(posedge HCLK);
    bus_read(4'd7, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL arming_is: got %h expected 0000", d); end
    bus_read(4'd0, d);
    checks++;
    if (d !== 16'hFFFF) begin errors++; $display("FAIL arming_data: got %h expected ffff", d); end
  endtask

  task automatic test_unmapped();
    logic [W-1:0] d;
    @(negedge HCLK);
    bus.reg_sel = 1'b1; bus.reg_wr = 1'b1; bus.reg_addr = 4'd12; bus.reg_wdata = '1;
    #1;
    checks++;
    if (bus.reg_rdata !== '0) begin
      errors++; $display("FAIL rdata_on_write: got %h expected 0000", bus.reg_rdata);
    end
    @(posedge HCLK); #1;
    bus.reg_sel = 1'b0; bus.reg_wr = 1'b0;
    bus_read(4'd12, d);
    checks++;
    if (d !== '0) begin errors++; $display("FAIL unmapped_read: got %h expected 0000", d); end
    for (int a = 1; a <= 8; a++) begin
      if (a == 5 || a == 6) continue;
      bus_read(4'(a), d);
      checks++;
      if (d !== '0) begin errors++; $display("FAIL unmapped_side[%0d]: got %h expected 0000", a, d); end
    end
  endtask

  task automatic test_dir_data();
    logic [W-1:0] d;
    bus_write(4'd1, 16'h00FF);
    checks++;
    if (gpio_dir !== 16'h00FF) begin errors++; $display("FAIL dir_pin: got %h expected 00ff", gpio_dir); end
    @(negedge HCLK);
    bus.reg_sel = 1'b1; bus.reg_wr = 1'b1; bus.reg_addr = 4'd0; bus.reg_wdata = 16'hA5A5;
    #1;
    checks++;
    if (gpio_dout !== 16'h0000) begin errors++; $display("FAIL dout_early: got %h expected 0000", gpio_dout); end
    @(posedge HCLK); #1;
    bus.reg_sel = 1'b0; bus.reg_wr = 1'b0;
    checks++;
    if (gpio_dout !== 16'hA5A5) begin errors++; $display("FAIL dout_pin: got %h expected a5a5", gpio_dout); end
    bus_read(4'd8, d);
    checks++;
    if (d !== 16'hA5A5) begin errors++; $display("FAIL out_read: got %h expected a5a5", d); end
  endtask

  task automatic test_pulls();
    logic [W-1:0] d;
    bus_write(4'd2, 16'h000F);
    bus_write(4'd3, 16'h00FF);
    checks++;
    if (gpio_pu !== 16'h000F) begin errors++; $display("FAIL pu_pin: got %h expected 000f", gpio_pu); end
    checks++;
    if (gpio_pd !== 16'h00F0) begin errors++; $display("FAIL pd_pin: got %h expected 00f0", gpio_pd); end
    bus_read(4'd3, d);
    checks++;
    if (d !== 16'h00FF) begin errors++; $display("FAIL pd_read: got %h expected 00ff", d); end
  endtask

  task automatic test_edge_irq();
    logic [W-1:0] d;
    bus_write(4'd6, 16'h0008);
    bus_write(4'd5, 16'h0008);
    @(negedge HCLK); gpio_din[3] = 1'b0;
    repeat (4) @(posedge HCLK);
    bus_read(4'd7, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL edge_falling_ignored: got %h expected 0000", d); end
    bus_write(4'd4, 16'h0008);
    @(negedge HCLK); gpio_din[3] = 1'b1;
    @(posedge HCLK);
    @(posedge HCLK); #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL edge_irq_early: got %b expected 0", irq); end
    bus.reg_sel = 1'b1; bus.reg_wr = 1'b0; bus.reg_addr = 4'd0;
    #1;
    checks++;
    if (bus.reg_rdata[3] !== 1'b1) begin errors++; $display("FAIL edge_data: got %h expected bit3 set", bus.reg_rdata); end
    bus.reg_sel = 1'b0;
    @(posedge HCLK); #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL edge_irq: got %b expected 1", irq); end
    bus_read(4'd7, d);
    checks++;
    if (d !== 16'h0008) begin errors++; $display("FAIL edge_is: got %h expected 0008", d); end
    bus_write(4'd7, 16'h0008);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL edge_irq_clear: got %b expected 0", irq); end
    bus_read(4'd7, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL edge_is_clear: got %h expected 0000", d); end
  endtask

  task automatic test_level_set_wins();
    logic [W-1:0] d;
    @(negedge HCLK); gpio_din[0] = 1'b0;
    repeat (4) @(posedge HCLK);
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL level_irq_masked: got %b expected 0", irq); end
    bus_write(4'd7, 16'h0001);
    bus_read(4'd7, d);
    checks++;
    if (d !== 16'h0001) begin errors++; $display("FAIL level_set_wins: got %h expected 0001", d); end
    @(negedge HCLK); gpio_din[0] = 1'b1;
    repeat (4) @(posedge HCLK);
    bus_write(4'd5, 16'hFFFF);
    bus_read(4'd7, d);
    checks++;
    if (d !== 16'h0001) begin errors++; $display("FAIL itype_keeps_is: got %h expected 0001", d); end
    bus_write(4'd7, 16'h0001);
    bus_read(4'd7, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL level_clear: got %h expected 0000", d); end
  endtask

  task automatic test_random();
    logic [3:0]   a;
    logic [W-1:0] d;
    logic [W-1:0] exp;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(3) == 0) begin
        @(negedge HCLK); gpio_din = W'($urandom);
      end
      a = 4'($urandom_range(15));
      d = W'($urandom);
      if ($urandom_range(1) == 1) begin
        bus_write(a, d);
      end else begin
        @(negedge HCLK);
        bus.reg_sel = 1'b1; bus.reg_wr = 1'b0; bus.reg_addr = a;
        #1;
        exp = model_read(a);
        checks++;
        if (bus.reg_rdata !== exp) begin
          errors++; $display("FAIL rand_read[%0d] addr %0d: got %h expected %h", n, a, bus.reg_rdata, exp);
        end
        @(posedge HCLK); #1;
        bus.reg_sel = 1'b0;
      end
      checks++;
      if (gpio_dout !== m_out || gpio_dir !== m_dir || gpio_pu !== m_pu ||
          gpio_pd !== (m_pd & ~m_pu) || irq !== |(m_is & m_im)) begin
        errors++;
        $display("FAIL rand_pins[%0d]: dout=%h dir=%h pu=%h pd=%h irq=%b expected %h %h %h %h %b",
                 n, gpio_dout, gpio_dir, gpio_pu, gpio_pd, irq,
                 m_out, m_dir, m_pu, m_pd & ~m_pu, |(m_is & m_im));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] d;
    bus_write(4'd1, 16'hFFFF);
    bus_write(4'd0, 16'h1234);
    bus_write(4'd4, 16'hFFFF);
    @(posedge HCLK); #2;
    HRESETn = 1'b0;
    #1;
    checks++;
    if ({gpio_dout, gpio_dir, irq} !== '0) begin
      errors++; $display("FAIL async_reset_pins: dout=%h dir=%h irq=%b expected 0", gpio_dout, gpio_dir, irq);
    end
    bus.reg_sel = 1'b1; bus.reg_wr = 1'b0; bus.reg_addr = 4'd4;
    #1;
    checks++;
    if (bus.reg_rdata !== '0) begin errors++; $display("FAIL async_reset_im: got %h expected 0000", bus.reg_rdata); end
    bus.reg_sel = 1'b0;
    @(negedge HCLK); HRESETn = 1'b1;
    gpio_din = '1;
    repeat (5) @(posedge HCLK);
    bus_read(4'd0, d);
    checks++;
    if (d !== 16'hFFFF) begin errors++; $display("FAIL post_reset_data: got %h expected ffff", d); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.reg_sel = 1'b0; bus.reg_wr = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    HRESETn = 1'b0;
    gpio_din = '1;
    test_reset();
    test_arming();
    test_unmapped();
    test_dir_data();
    test_pulls();
    test_edge_irq();
    test_level_set_wins();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
